// File: rtl/sram_req_sched.sv
// sram_req_sched: round-robin scheduler issuing one SRAM controller command at a time.
// Four level requests (slave write/read, master write/read) are filtered by FIFO status,
// arbitrated round-robin in IDLE, held in ISSUE until the matching completion hint,
// then a one-cycle GAP pulses done before the next arbitration.
// Optional macro SRAM_REQ_SCHED_TIMEOUT_EN adds an ISSUE watchdog (TIMEOUT_CYCLES)
// with a sticky timeout_err flag; without it timeout_err is tied low.
module sram_req_sched #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       fifo_i_full,
  input  logic       fifo_i_empty,
  input  logic       fifo_o_full,
  input  logic       fifo_o_empty,
  input  logic       slave_hint,
  input  logic       master_hint,
  output logic       slave_write,
  output logic       slave_read,
  output logic       master_write,
  output logic       master_read,
  output logic [3:0] grant,
  output logic [3:0] done,
  output logic       busy,
  output logic       timeout_err
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StGap   = 2'd2;

  // Reject out-of-range watchdog settings at elaboration.
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("sram_req_sched: TIMEOUT_CYCLES must be within 2..255");
  end

  logic [1:0] state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [3:0] grant_q, grant_d;
  logic [3:0] done_q, done_d;
  logic [3:0] eligible;
  logic [1:0] sel_idx;
  logic       sel_valid;
  logic       hint_match;

`ifdef SRAM_REQ_SCHED_TIMEOUT_EN
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
`endif

  // Requests that can make progress given the current FIFO levels.
  assign eligible = req & {~fifo_i_empty, ~fifo_o_full, ~fifo_o_empty, ~fifo_i_full};

  // Slave-side grants complete on slave_hint, master-side on master_hint.
  assign hint_match = (grant_q[0] | grant_q[1]) ? slave_hint : master_hint;

  // Round-robin search starting one past the last served index.
  always_comb begin
    logic [1:0] idx;
    sel_idx   = '0;
    sel_valid = 1'b0;
    idx       = '0;
    for (int i = 1; i <= 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!sel_valid && eligible[idx]) begin
        sel_valid = 1'b1;
        sel_idx   = idx;
      end
    end
  end

  // Next-state logic for the IDLE/ISSUE/GAP sequencer.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    done_d  = '0;
`ifdef SRAM_REQ_SCHED_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    case (state_q)
      StIdle: begin
        if (sel_valid) begin
          grant_d = 4'b0001 << sel_idx;
          ptr_d   = sel_idx;
          state_d = StIssue;
`ifdef SRAM_REQ_SCHED_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      StIssue: begin
        if (hint_match) begin
          done_d  = grant_q;
          grant_d = '0;
          state_d = StGap;
        end
`ifdef SRAM_REQ_SCHED_TIMEOUT_EN
        else if (cnt_q == TimeoutLast) begin
          // Abandon the command; done stays low so the requester sees no completion.
          grant_d = '0;
          err_d   = 1'b1;
          state_d = StGap;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      StGap: begin
        state_d = StIdle;
      end
      default: begin
        grant_d = '0;
        state_d = StIdle;
      end
    endcase
  end

  // State registers; reset leaves ptr at 3 so the first search begins at req[0].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= 2'd3;
      grant_q <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      done_q  <= done_d;
    end
  end

`ifdef SRAM_REQ_SCHED_TIMEOUT_EN
  // Watchdog counter and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign timeout_err = err_q;
`else
  assign timeout_err = 1'b0;
`endif

  // Commands mirror the grant only while the operation is in flight.
  always_comb begin
    {master_read, master_write, slave_read, slave_write} = '0;
    if (state_q == StIssue) begin
      {master_read, master_write, slave_read, slave_write} = grant_q;
    end
  end

  assign grant = grant_q;
  assign done  = done_q;
  assign busy  = (state_q != StIdle);

endmodule

// File: doc/sram_req_sched.md
SRAM_REQ_SCHED -- requirements
Module: sram_req_sched

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16: ISSUE-state cycles allowed before abort; 2..255; used only with the timeout feature.
REQ-002 clk  in  1  sole clock; all state on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 req  in  4  level requests: [0] slave write, [1] slave read, [2] master write, [3] master read.
REQ-005 fifo_i_full, fifo_i_empty, fifo_o_full, fifo_o_empty  in  1 each  SRAM controller FIFO status.
REQ-006 slave_hint, master_hint  in  1 each  one-cycle completion pulses from the SRAM controller.
REQ-007 slave_write, slave_read, master_write, master_read  out  1 each  command levels to the SRAM controller.
REQ-008 grant  out  4  one-hot owner of the operation in flight, bit order as req.
REQ-009 done  out  4  one-cycle one-hot completion pulse, bit order as req.
REQ-010 busy  out  1  high whenever state is not IDLE.
REQ-011 timeout_err  out  1  sticky timeout flag.

Function
REQ-012 Eligibility: req[0] needs !fifo_i_full; req[1] needs !fifo_o_empty; req[2] needs !fifo_o_full; req[3] needs !fifo_i_empty; ineligible requests are skipped, never queued.
REQ-013 FSM states: IDLE, ISSUE, GAP; exactly one operation in flight at any time.
REQ-014 IDLE: if any request is eligible, select by round-robin starting at (ptr+1) mod 4, register grant, set ptr to selected index, go to ISSUE; otherwise stay.
REQ-015 ISSUE: exactly one command output, the one matching grant, is high; all others low.
REQ-016 ISSUE exit: grant[0]/[1] leaves on slave_hint, grant[2]/[3] on master_hint; the hint of the other side is ignored.
REQ-017 Latency: eligible request sampled at edge N gives grant and command high from N+1; hint sampled at edge H gives command low and done pulse in cycle H+1, then IDLE at H+2.
REQ-018 GAP lasts exactly one cycle: done asserted for the granted bit, grant and commands low; this guarantees the controller returns idle before the next command.
REQ-019 A request dropped or FIFO status changed during ISSUE does not abort the operation; eligibility is evaluated in IDLE only.
REQ-020 Simultaneous eligible requests: only the round-robin winner is granted; each continuously eligible requester is served at least once in any four consecutive grants.
REQ-021 Hint arriving in IDLE or GAP is ignored and produces no done pulse.
REQ-022 Pointer wraps 3 -> 0; ptr is 2 bits, arithmetic modulo 4.

Reset
REQ-023 rst_n low asynchronously forces state IDLE, ptr = 3, grant = 0, done = 0, all commands low, busy = 0, timeout_err = 0, timeout counter = 0.
REQ-024 Reset asserted during ISSUE abandons the operation with no done pulse; the first grant after release starts search at req[0].

Configuration
REQ-025 Macro SRAM_REQ_SCHED_TIMEOUT_EN defined: 8-bit counter clears on entering ISSUE and increments each ISSUE cycle; reaching TIMEOUT_CYCLES without the matching hint drops the command, sets timeout_err, goes to GAP with done held low; ptr keeps the timed-out index.
REQ-026 Macro undefined: no counter, ISSUE waits indefinitely for the hint, timeout_err tied 0; port list unchanged.

Verification
REQ-027 Reset then req=0001, all FIFOs empty/not full; slave_hint pulsed 3 cycles after slave_write rises -> grant=0001 one cycle after request, slave_write high 3 cycles, done=0001 one cycle, IDLE next.
REQ-028 req=1111 held, fifo_i/o both half full, hints returned after 2 cycles -> grant order 0001, 0010, 0100, 1000, 0001.
REQ-029 req=0010 with fifo_o_empty=1 for 10 cycles -> grant stays 0, busy 0; fifo_o_empty falls -> slave_read high next cycle.
REQ-030 grant=0100 in ISSUE, slave_hint pulsed, master_hint withheld -> master_write stays high, no done; then master_hint -> done=0100.
REQ-031 rst_n low mid-ISSUE with grant=1000 -> all outputs 0 immediately; after release req=1111 -> first grant 0001.
REQ-032 With SRAM_REQ_SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=4, no hint -> command low after 4 ISSUE cycles, timeout_err=1 until reset, done stays 0, next grant proceeds.
